// File: rtl/heater_pkg.sv
// Shared types and default constants for the heater enable sequencer.
package heater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE
  } hs_state_e;

  localparam int HS_N             = 32;
  localparam int HS_STEP_CYCLES   = 1024;
  localparam int HS_CLEAR_CYCLES  = 4;
  localparam int HS_SETTLE_CYCLES = 2;
  localparam int HS_MAX_RETRY     = 3;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int hs_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/heater_prio_enc.sv
// Lowest-index-first priority encoder; combinational, idx is 0 when nothing requests.
module heater_prio_enc #(
  parameter int N = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        vld_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/heater_sequencer.sv
// Paces heater channel enables one step at a time and services channel errors with
// clear pulses, latching a fault after too many retries. Outputs change one cycle after the deciding edge.
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int N             = HS_N,
  parameter int STEP_CYCLES   = HS_STEP_CYCLES,
  parameter int CLEAR_CYCLES  = HS_CLEAR_CYCLES,
  parameter int SETTLE_CYCLES = HS_SETTLE_CYCLES,
  parameter int MAX_RETRY     = HS_MAX_RETRY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] target_enable,
  input  logic [N-1:0] fault_clear,
  input  logic [N-1:0] heater_error,
  output logic [N-1:0] heater_enable,
  output logic [N-1:0] heater_err_clear,
  output logic [N-1:0] fault,
  output logic         busy,
  output logic [15:0]  error_total
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = hs_width(STEP_CYCLES);
  localparam int PW = hs_width((CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES);
  localparam int RW = hs_width(MAX_RETRY + 1);

  hs_state_e    state_q;
  logic [N-1:0] en_q;
  logic [N-1:0] clr_q;
  logic [N-1:0] fault_q;
  logic [N-1:0] target_q;
  logic [SW-1:0] step_cnt_q;
  logic [PW-1:0] phase_q;
  logic [RW-1:0] retry_q [N];
  logic [15:0]  total_q;

  logic [N-1:0]  pend_up_d, pend_dn_d, err_cand_d;
  logic          up_vld, dn_vld, err_vld;
  logic [IW-1:0] up_idx, dn_idx, err_idx;

  assign pend_up_d  = target_enable & ~en_q & ~fault_q;
  assign pend_dn_d  = ~target_enable & en_q;
  assign err_cand_d = heater_error & en_q;

  heater_prio_enc #(.N(N), .IW(IW)) u_up_enc  (.req_i(pend_up_d),  .vld_o(up_vld),  .idx_o(up_idx));
  heater_prio_enc #(.N(N), .IW(IW)) u_dn_enc  (.req_i(pend_dn_d),  .vld_o(dn_vld),  .idx_o(dn_idx));
  heater_prio_enc #(.N(N), .IW(IW)) u_err_enc (.req_i(err_cand_d), .vld_o(err_vld), .idx_o(err_idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      clr_q      <= '0;
      fault_q    <= '0;
      target_q   <= '0;
      step_cnt_q <= '0;
      phase_q    <= '0;
      total_q    <= '0;
      for (int i = 0; i < N; i++) retry_q[i] <= '0;
    end else begin
      target_q <= target_enable;
      if (step_cnt_q != '0) step_cnt_q <= step_cnt_q - SW'(1);

      for (int i = 0; i < N; i++) begin
        if ((target_q[i] && !target_enable[i]) || fault_clear[i]) retry_q[i] <= '0;
        if (fault_clear[i]) fault_q[i] <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (err_vld) begin
            if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
            if (int'(retry_q[err_idx]) < MAX_RETRY) begin
              retry_q[err_idx] <= retry_q[err_idx] + RW'(1);
              clr_q[err_idx]   <= 1'b1;
              phase_q          <= PW'(CLEAR_CYCLES - 1);
              state_q          <= ST_CLEAR;
            end else begin
              // Retries exhausted: drop the channel immediately, outside the pacing.
              fault_q[err_idx] <= 1'b1;
              en_q[err_idx]    <= 1'b0;
            end
          end else if (step_cnt_q == '0 && dn_vld) begin
            en_q[dn_idx] <= 1'b0;
            step_cnt_q   <= SW'(STEP_CYCLES - 1);
          end else if (step_cnt_q == '0 && up_vld) begin
            en_q[up_idx] <= 1'b1;
            step_cnt_q   <= SW'(STEP_CYCLES - 1);
          end
        end
        ST_CLEAR: begin
          if (phase_q == '0) begin
            clr_q   <= '0;
            phase_q <= PW'(SETTLE_CYCLES - 1);
            state_q <= ST_SETTLE;
          end else begin
            phase_q <= phase_q - PW'(1);
          end
        end
        ST_SETTLE: begin
          if (phase_q == '0) state_q <= ST_IDLE;
          else phase_q <= phase_q - PW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign heater_enable    = en_q;
  assign heater_err_clear = clr_q;
  assign fault            = fault_q;
  assign error_total      = total_q;
  assign busy = (state_q != ST_IDLE) || (step_cnt_q != '0) || (|pend_up_d) || (|pend_dn_d);

endmodule

// File: doc/heater_sequencer.md
HEATER_SEQUENCER -- requirements
Module: heater_sequencer

Interface
REQ-001 Parameter N, default 32: number of heater channels served.
REQ-002 Parameter STEP_CYCLES, default 1024: minimum clk cycles between successive paced enable/disable changes (limits current steps).
REQ-003 Parameter CLEAR_CYCLES, default 4: err_clear pulse width in cycles.
REQ-004 Parameter SETTLE_CYCLES, default 2: wait after an err_clear pulse before errors are re-sampled.
REQ-005 Parameter MAX_RETRY, default 3: error services allowed per channel before it is latched faulted.
REQ-006 clk  in  1  single clock; all logic synchronous to rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 target_enable  in  N  software-requested channel enables (GPIO).
REQ-009 fault_clear  in  N  per-channel single-cycle strobe; releases a latched fault.
REQ-010 heater_error  in  N  per-channel error from heater channels.
REQ-011 heater_enable  out  N  paced enables to heater channels.
REQ-012 heater_err_clear  out  N  error-clear pulses to heater channels.
REQ-013 fault  out  N  latched per-channel fault flags.
REQ-014 busy  out  1  high while FSM not IDLE, step timer nonzero, or any change pending.
REQ-015 error_total  out  16  saturating count of error services since reset.

Function
REQ-016 Pending-up set = target_enable & ~heater_enable & ~fault; pending-down set = ~target_enable & heater_enable.
REQ-017 Step timer: a paced change is allowed only when step_cnt==0; each change loads step_cnt=STEP_CYCLES-1, decrementing to 0 every cycle regardless of FSM state.
REQ-018 FSM states IDLE, CLEAR, SETTLE; paced changes occur only in IDLE.
REQ-019 In IDLE, priority per cycle: error service > one disable (lowest pending-down index) > one enable (lowest pending-up index); at most one channel changes per cycle.
REQ-020 Service candidate: channel i with heater_error[i]=1 and heater_enable[i]=1; lowest index selected; errors on disabled channels ignored.
REQ-021 Service entry (IDLE->CLEAR): if retry_cnt[k]<MAX_RETRY, increment retry_cnt[k]; else set fault[k] and clear heater_enable[k] in the same cycle, unpaced, step timer unaffected.
REQ-022 CLEAR: heater_err_clear[k]=1 for exactly CLEAR_CYCLES cycles, only bit k; then SETTLE.
REQ-023 SETTLE: SETTLE_CYCLES cycles, then IDLE; a still-asserted error is serviced again as a new event.
REQ-024 Faulted channel: heater_enable forced 0, target_enable ignored until fault_clear[i].
REQ-025 fault_clear[i] clears fault[i] and retry_cnt[i] next cycle; re-enable then follows normal pacing.
REQ-026 target_enable[i] falling clears retry_cnt[i].
REQ-027 target_enable changes during CLEAR/SETTLE are held as pending and executed in IDLE when timer permits.
REQ-028 error_total increments by 1 per service entry, saturates at 16'hFFFF.
REQ-029 Output latency: heater_enable/heater_err_clear registered, change visible one cycle after the deciding edge.

Reset
REQ-030 On reset: heater_enable=0, heater_err_clear=0, fault=0, retry_cnt=0, error_total=0, step_cnt=0, FSM=IDLE, busy=0.
REQ-031 Reset asserted mid-CLEAR terminates the pulse the next cycle; no partial state retained.

Structure
REQ-032 Shared package heater_pkg holds FSM state enum and default parameter constants.
REQ-033 One sub-module heater_prio_enc: N-bit lowest-index priority encoder with valid flag, instantiated for up, down and error selection.
REQ-034 heater_sequencer sits between GPIO and heater channels in the top level; no other logic changes.

Verification (STEP_CYCLES=8, CLEAR_CYCLES=4, SETTLE_CYCLES=2, MAX_RETRY=3, N=32)
REQ-035 target_enable 0->0x0000000F -> bits 0,1,2,3 enable in order, exactly 8 cycles apart; busy drops after last timer expiry.
REQ-036 Channels 0-3 enabled, target_enable->0x00000005 -> bit 1 then bit 3 disable, 8 cycles apart; bits 0,2 unchanged.
REQ-037 heater_error[2] pulsed 1 cycle on enabled ch2 -> heater_err_clear=0x4 for 4 cycles, error_total=1, fault=0, ch2 stays enabled.
REQ-038 heater_error[5] held high on enabled ch5 -> 3 clear pulses, 4th service sets fault[5], heater_enable[5]=0 same cycle, error_total=4; fault_clear[5] -> ch5 re-enabled after pacing.
REQ-039 Simultaneous heater_error[7] and heater_error[3] plus pending enable on ch9 -> ch3 serviced, then ch7, then ch9 enabled; never two err_clear bits high.
REQ-040 reset during CLEAR of ch1 -> all outputs 0 next cycle, FSM IDLE, counters 0.
